mod_mul64_arb: RTL and testbench
================================

MOD_MUL64_ARB -- requirements
Module: mod_mul64_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one modular multiplier (2..8).
REQ-002 Parameter W, default 64, operand/modulus/result width.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset; also drives the reset of the shared engine.
REQ-005 req  input  NUM_REQ  per-requester request level; operands valid while high.
REQ-006 a_in, b_in, n_in  input  NUM_REQ*W each  flattened operands; slice i = bits [i*W +: W].
REQ-007 ack  output  NUM_REQ  one-hot, 1-cycle pulse: operands of requester i captured.
REQ-008 rsp_valid  output  NUM_REQ  one-hot, 1-cycle pulse: result for requester i on result.
REQ-009 result  output  W  (a*b) mod n of the completed job; held until the next rsp_valid.
REQ-010 err  output  1  asserted with rsp_valid when the job was rejected (see REQ-028).
REQ-011 busy  output  1  high in every state except ARB.

Function
REQ-012 Shall instantiate exactly one modular-multiply engine (a*b mod n, level start/done protocol) and time-share it.
REQ-013 States: ARB, RUN, RESP, DRAIN; reset state ARB.
REQ-014 ARB: if any req high, grant index g = first set bit at or after pointer ptr (wrapping); capture a/b/n slice g into operand registers; pulse ack[g]; go RUN. No request: stay.
REQ-015 On grant, ptr <= (g+1) mod NUM_REQ; a non-requesting index never consumes a turn.
REQ-016 RUN: eng_start held high; completion = rising edge of engine done (done & ~done_q); go RESP on that edge.
REQ-017 RESP: eng_start low; result <= engine remainder; pulse rsp_valid[g]; go DRAIN.
REQ-018 DRAIN: one cycle with eng_start low so the engine returns to idle; then ARB.
REQ-019 Minimum gap ack -> rsp_valid = engine latency + 2 cycles; back-to-back jobs separated by at least 2 cycles (RESP, DRAIN).
REQ-020 Requester shall drop req the cycle after ack; req still high in the next ARB is a new job.
REQ-021 req changes outside ARB are ignored; operand changes after ack do not affect the running job.
REQ-022 Simultaneous requests: exactly one ack per ARB cycle; never two bits of ack or rsp_valid set.
REQ-023 Operand widths: engine product 2W bits, remainder W bits; result = remainder, no truncation.

Reset
REQ-024 On rst: state ARB, ptr 0, ack 0, rsp_valid 0, err 0, result 0, busy 0, eng_start 0, done_q 0, operand registers 0.
REQ-025 rst mid-job aborts it: no rsp_valid for the aborted requester; engine reset in the same cycle.
REQ-026 First cycle after rst deasserts may grant (ARB active).

Configuration
REQ-027 Macro MOD_MUL64_ARB_ZERO_CHECK_EN selects zero-modulus rejection.
REQ-028 Defined: in ARB, a granted job with n == 0 skips RUN, goes RESP with result 0, err 1; engine never started.
REQ-029 Undefined: n == 0 is passed to the engine unchanged; err tied to 0; result is whatever the engine produces.

Structure
REQ-030 Shared package holds state encoding constants (ARB/RUN/RESP/DRAIN, 2 bits) and the default W/NUM_REQ values.
REQ-031 One sub-module: the round-robin priority picker (rr_pick: req, ptr -> one-hot grant, index, any); FSM and engine instance stay in the top.

Verification
REQ-032 Single job: req[0], a=7, b=9, n=10 -> ack[0] one cycle later, rsp_valid[0] with result=3, err=0.
REQ-033 Max operands: a=b=2^64-1, n=2^64-59 -> result=3364.
REQ-034 req[0] and req[2] rise together, ptr=0 -> ack[0] first, rsp_valid[0]; then ack[2], rsp_valid[2]; ptr=3 afterwards.
REQ-035 All four req held high for 8 jobs -> grant order 0,1,2,3,0,1,2,3; never two acks in one cycle.
REQ-036 rst asserted during RUN of job for req[1] -> no rsp_valid[1]; all outputs 0 next cycle; new req[1] job completes correctly.
REQ-037 With MOD_MUL64_ARB_ZERO_CHECK_EN: n=0 on req[3] -> rsp_valid[3], err=1, result=0, engine start never asserted.

Source files
------------

// File: rtl/mod_mul64_arb_pkg.sv
// rtl/mod_mul64_arb_pkg.sv - shared constants and types for the modular-multiply arbiter
//
// Purpose: holds the arbiter state encoding (2 bits), the engine state type,
//          and the default operand width / requester count.
// Ports:   none (package).
package mod_mul64_arb_pkg;

  localparam int DEF_W       = 64;
  localparam int DEF_NUM_REQ = 4;

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    ARB   = ST_ARB,
    RUN   = ST_RUN,
    RESP  = ST_RESP,
    DRAIN = ST_DRAIN
  } arb_state_t;

  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_CALC = 2'd1,
    ENG_DONE = 2'd2
  } eng_state_t;

endpackage

// File: rtl/mod_mul64_arb_engine.sv
// rtl/mod_mul64_arb_engine.sv - sequential (a*b) mod n engine with level start/done
//
// Purpose: forms the 2W-bit product, then reduces it one product bit per cycle
//          by restoring division; done stays high while start stays high.
// Ports:   clk_i, rst_i     - clock, synchronous active-high reset
//          start_i          - level request; drop it to return to idle
//          a_i, b_i, n_i    - operands and modulus, sampled when leaving idle
//          done_o           - result valid on rem_o
//          rem_o            - W-bit remainder
module mod_mul64_arb_engine
  import mod_mul64_arb_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] n_i,
  output logic         done_o,
  output logic [W-1:0] rem_o
);

  localparam int CW = $clog2(2 * W);

  eng_state_t      state_q, state_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic [W-1:0]    n_q, n_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Partial remainder stays below n, so shifting in one bit needs one extra bit.
  logic [W:0]      shifted;
  logic [W:0]      trial;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ENG_IDLE;
      prod_q  <= '0;
      n_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    n_d     = n_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    shifted = {rem_q, prod_q[2*W-1]};
    trial   = shifted - {1'b0, n_q};
    case (state_q)
      ENG_IDLE: begin
        if (start_i) begin
          prod_d  = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
          n_d     = n_i;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = ENG_CALC;
        end
      end
      ENG_CALC: begin
        rem_d  = (shifted >= {1'b0, n_q}) ? trial[W-1:0] : shifted[W-1:0];
        prod_d = {prod_q[2*W-2:0], 1'b0};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(2 * W - 1)) begin
          state_d = ENG_DONE;
        end
      end
      ENG_DONE: begin
        done_o = 1'b1;
        if (!start_i) begin
          state_d = ENG_IDLE;
        end
      end
      default: state_d = ENG_IDLE;
    endcase
  end

  assign rem_o = rem_q;

endmodule

// File: rtl/mod_mul64_arb_rr_pick.sv
// rtl/mod_mul64_arb_rr_pick.sv - round-robin priority picker
//
// Purpose: selects the first set request at or after ptr_i, wrapping around.
// Ports:   req_i   - request vector
//          ptr_i   - index with highest priority this cycle
//          grant_o - one-hot grant (zero when no request)
//          idx_o   - index of the granted requester
//          any_o   - at least one request present
module mod_mul64_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  always_comb begin
    int pos;
    logic [IW-1:0] p;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    p       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      p = IW'(pos);
      if (!any_o && req_i[p]) begin
        any_o      = 1'b1;
        idx_o      = p;
        grant_o[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_mul64_arb.sv
// rtl/mod_mul64_arb.sv - round-robin arbiter time-sharing one modular multiplier
//
// Purpose: grants one requester at a time, runs (a*b) mod n on the shared
//          engine and returns the result with a one-hot rsp_valid pulse.
// Config:  MOD_MUL64_ARB_ZERO_CHECK_EN - reject jobs with n == 0 (err=1,
//          result=0, engine not started). Undefined: n == 0 goes to the engine.
// Ports:   clk, rst            - clock, synchronous active-high reset
//          req                 - per-requester request level
//          a_in, b_in, n_in    - flattened operands, slice i = [i*W +: W]
//          ack                 - one-hot pulse, operands of requester captured
//          rsp_valid           - one-hot pulse, result valid for requester
//          result              - last completed result, held
//          err                 - rejected job, pulses with rsp_valid
//          busy                - high outside ARB
module mod_mul64_arb
  import mod_mul64_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int W       = DEF_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*W-1:0] a_in,
  input  logic [NUM_REQ*W-1:0] b_in,
  input  logic [NUM_REQ*W-1:0] n_in,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [W-1:0]         result,
  output logic                 err,
  output logic                 busy
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       g_q, g_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [W-1:0]        n_q, n_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  rsp_q, rsp_d;
  logic [W-1:0]        result_q, result_d;
  logic                err_q, err_d;
  logic                done_q;
`ifdef MOD_MUL64_ARB_ZERO_CHECK_EN
  logic                zero_q, zero_d;
`endif

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [W-1:0]        sel_a, sel_b, sel_n;

  logic                eng_start;
  logic                eng_done;
  logic [W-1:0]        eng_rem;

  mod_mul64_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  mod_mul64_arb_engine #(
    .W (W)
  ) u_engine (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (eng_start),
    .a_i     (a_q),
    .b_i     (b_q),
    .n_i     (n_q),
    .done_o  (eng_done),
    .rem_o   (eng_rem)
  );

  assign sel_a = a_in[int'(pick_idx)*W +: W];
  assign sel_b = b_in[int'(pick_idx)*W +: W];
  assign sel_n = n_in[int'(pick_idx)*W +: W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      ptr_q    <= '0;
      g_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      ack_q    <= '0;
      rsp_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef MOD_MUL64_ARB_ZERO_CHECK_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      g_q      <= g_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      ack_q    <= ack_d;
      rsp_q    <= rsp_d;
      result_q <= result_d;
      err_q    <= err_d;
      done_q   <= eng_done;
`ifdef MOD_MUL64_ARB_ZERO_CHECK_EN
      zero_q   <= zero_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    g_d      = g_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    ack_d    = '0;
    rsp_d    = '0;
    result_d = result_q;
    err_d    = 1'b0;
`ifdef MOD_MUL64_ARB_ZERO_CHECK_EN
    zero_d   = zero_q;
`endif
    case (state_q)
      ARB: begin
        if (pick_any) begin
          g_d   = pick_idx;
          a_d   = sel_a;
          b_d   = sel_b;
          n_d   = sel_n;
          ack_d = pick_grant;
          ptr_d = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
          state_d = RUN;
`ifdef MOD_MUL64_ARB_ZERO_CHECK_EN
          zero_d = (sel_n == '0);
          if (sel_n == '0) begin
            state_d = RESP;
          end
`endif
        end
      end
      RUN: begin
        // Only a fresh done edge counts, so a stale level cannot end a job early.
        if (eng_done && !done_q) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_d    = NUM_REQ'(1) << g_q;
        result_d = eng_rem;
`ifdef MOD_MUL64_ARB_ZERO_CHECK_EN
        if (zero_q) begin
          result_d = '0;
          err_d    = 1'b1;
        end
`endif
        state_d = DRAIN;
      end
      DRAIN: begin
        // Engine sees start low here and returns to idle before the next grant.
        state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  assign eng_start = (state_q == RUN);
  assign ack       = ack_q;
  assign rsp_valid = rsp_q;
  assign result    = result_q;
  assign err       = err_q;
  assign busy      = (state_q != ARB);

endmodule

// File: tb/tb_mod_mul64_arb.sv
// tb/tb_mod_mul64_arb.sv - directed self-checking bench for mod_mul64_arb
module tb_mod_mul64_arb;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic [N*W-1:0] n_in = '0;
  logic [N-1:0]   ack;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   result;
  logic           err;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mod_mul64_arb #(.NUM_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .n_in      (n_in),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .result    (result),
    .err       (err),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] n);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
    n_in[i*W +: W] = n;
  endtask

  task automatic wait_ack(input string tag, input logic [N-1:0] exp, output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        lat = c;
        break;
      end
    end
    check(tag, 64'(ack), 64'(exp));
  endtask

  task automatic wait_rsp(input string tag, input logic [N-1:0] exp_mask,
                          input logic [63:0] exp_res, input logic exp_err);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) break;
    end
    check({tag, "_mask"}, 64'(rsp_valid), 64'(exp_mask));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  // Whenever a grant or response appears, it must be a single bit.
  always @(negedge clk) begin
    if (!rst && ack != '0) check("ack_onehot", 64'($countones(ack)), 64'd1);
    if (!rst && rsp_valid != '0) check("rsp_onehot", 64'($countones(rsp_valid)), 64'd1);
  end

`ifdef MOD_MUL64_ARB_ZERO_CHECK_EN
  logic start_seen = 1'b0;
  always @(negedge clk) begin
    if (dut.eng_start) start_seen = 1'b1;
  end
`endif

  initial begin
    int lat;
    int seen;

    repeat (3) @(negedge clk);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_rsp", 64'(rsp_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // Single job: 7*9 mod 10 = 3, acked one cycle after req.
    set_ops(0, 64'd7, 64'd9, 64'd10);
    req = 4'b0001;
    wait_ack("single_ack", 4'b0001, lat);
    req = '0;
    check("single_ack_latency", 64'(lat), 64'd1);
    check("single_busy", 64'(busy), 64'd1);
    wait_rsp("single", 4'b0001, 64'd3, 1'b0);
    @(negedge clk);
    check("single_idle_busy", 64'(busy), 64'd0);

    // Max operands: (2^64-1)^2 mod (2^64-59) = 58^2 = 3364.
    set_ops(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC5);
    req = 4'b0001;
    wait_ack("max_ack", 4'b0001, lat);
    req = '0;
    wait_rsp("max", 4'b0001, 64'd3364, 1'b0);

    // Job on req[3] wraps the pointer back to 0: 100 mod 7 = 2.
    set_ops(3, 64'd10, 64'd10, 64'd7);
    req = 4'b1000;
    wait_ack("wrap_ack", 4'b1000, lat);
    req = '0;
    wait_rsp("wrap", 4'b1000, 64'd2, 1'b0);

    // req[0] and req[2] together with ptr 0: 12 mod 5 = 2, 42 mod 9 = 6.
    set_ops(0, 64'd3, 64'd4, 64'd5);
    set_ops(2, 64'd6, 64'd7, 64'd9);
    req = 4'b0101;
    wait_ack("pair_ack0", 4'b0001, lat);
    req[0] = 1'b0;
    wait_rsp("pair_rsp0", 4'b0001, 64'd2, 1'b0);
    wait_ack("pair_ack2", 4'b0100, lat);
    req[2] = 1'b0;
    wait_rsp("pair_rsp2", 4'b0100, 64'd6, 1'b0);

    // Pointer now 3: req[3] beats req[0]. 16 mod 6 = 4.
    set_ops(3, 64'd4, 64'd4, 64'd6);
    req = 4'b1001;
    wait_ack("ptr3_ack3", 4'b1000, lat);
    req[3] = 1'b0;
    wait_rsp("ptr3_rsp3", 4'b1000, 64'd4, 1'b0);
    wait_ack("ptr3_ack0", 4'b0001, lat);
    req = '0;
    wait_rsp("ptr3_rsp0", 4'b0001, 64'd2, 1'b0);

    // All four held high for eight jobs starting from ptr 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_ops(0, 64'd2, 64'd3, 64'd7);
    set_ops(1, 64'd3, 64'd4, 64'd7);
    set_ops(2, 64'd4, 64'd5, 64'd7);
    set_ops(3, 64'd5, 64'd6, 64'd7);
    req = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      logic [63:0] rr_exp [4];
      rr_exp[0] = 64'd6;
      rr_exp[1] = 64'd5;
      rr_exp[2] = 64'd6;
      rr_exp[3] = 64'd2;
      wait_ack($sformatf("rr_ack%0d", j), 4'(1 << (j % 4)), lat);
      wait_rsp($sformatf("rr_rsp%0d", j), 4'(1 << (j % 4)), rr_exp[j % 4], 1'b0);
    end
    req = '0;
    repeat (4) @(negedge clk);

    // Reset during RUN aborts the job for req[1].
    set_ops(1, 64'd11, 64'd13, 64'd17);
    req = 4'b0010;
    wait_ack("abort_ack", 4'b0010, lat);
    req = '0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst_ack", 64'(ack), 64'd0);
    check("abort_rst_rsp", 64'(rsp_valid), 64'd0);
    check("abort_rst_result", result, 64'd0);
    check("abort_rst_err", 64'(err), 64'd0);
    check("abort_rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) seen++;
    end
    check("abort_no_rsp", 64'(seen), 64'd0);
    set_ops(1, 64'd5, 64'd6, 64'd11);
    req = 4'b0010;
    wait_ack("after_abort_ack", 4'b0010, lat);
    req = '0;
    wait_rsp("after_abort", 4'b0010, 64'd8, 1'b0);

`ifdef MOD_MUL64_ARB_ZERO_CHECK_EN
    // Zero modulus on req[3] is rejected without touching the engine.
    repeat (2) @(negedge clk);
    start_seen = 1'b0;
    set_ops(3, 64'd9, 64'd9, 64'd0);
    req = 4'b1000;
    wait_ack("zero_ack", 4'b1000, lat);
    req = '0;
    wait_rsp("zero", 4'b1000, 64'd0, 1'b1);
    repeat (2) @(negedge clk);
    check("zero_no_start", 64'(start_seen), 64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
